// File: rtl/bus_access_arbiter.sv
// rtl/bus_access_arbiter.sv - two-port arbiter sharing one 68000 bus-cycle engine
module bus_access_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 24
) (
    input  logic              SYSCLK,
    input  logic              nRESET,
    input  logic              REQ0_VALID,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [1:0]        REQ0_SIZE,
    input  logic              REQ0_READ,
    input  logic [2:0]        REQ0_FC,
    input  logic [31:0]       REQ0_WDATA,
    output logic              REQ0_DONE,
    input  logic              REQ1_VALID,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [1:0]        REQ1_SIZE,
    input  logic              REQ1_READ,
    input  logic [2:0]        REQ1_FC,
    input  logic [31:0]       REQ1_WDATA,
    output logic              REQ1_DONE,
    output logic [31:0]       RDATA,
    output logic [1:0]        GRANT,
    input  logic              EXT_MASTER,
    output logic              ENG_START,
    output logic [ADDR_W-1:0] ENG_ADDR,
    output logic [1:0]        ENG_SIZE,
    output logic              ENG_READ,
    output logic [2:0]        ENG_FC,
    output logic [31:0]       ENG_WDATA,
    input  logic              ENG_BUSY,
    input  logic              ENG_DONE,
    input  logic [31:0]       ENG_RDATA
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // S_DONE is the cycle the completion pulse is visible; no arbitration happens in it
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          starve_q, starve_d;
    logic [1:0]          grant_q, grant_d;
    logic                start_q, start_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                read_q, read_d;
    logic [2:0]          fc_q, fc_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                pick1;

    // Port 1 wins only when port 0 is absent or port 1 has been starved long enough
    assign pick1 = REQ1_VALID && (!REQ0_VALID || (starve_q >= LIMIT));

    // Next-state logic: arbitration, engine handshake and completion routing
    always_comb begin
        state_d  = state_q;
        starve_d = REQ1_VALID ? starve_q : 4'd0;
        grant_d  = grant_q;
        start_d  = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        size_d   = size_q;
        read_d   = read_q;
        fc_d     = fc_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (!EXT_MASTER && (REQ0_VALID || REQ1_VALID)) begin
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                    if (pick1) begin
                        grant_d  = 2'b10;
                        starve_d = 4'd0;
                        addr_d   = REQ1_ADDR;
                        size_d   = REQ1_SIZE;
                        read_d   = REQ1_READ;
                        fc_d     = REQ1_FC;
                        wdata_d  = REQ1_WDATA;
                    end else begin
                        grant_d = 2'b01;
                        if (REQ1_VALID && (starve_q < LIMIT)) begin
                            starve_d = starve_q + 4'd1;
                        end
                        addr_d  = REQ0_ADDR;
                        size_d  = REQ0_SIZE;
                        read_d  = REQ0_READ;
                        fc_d    = REQ0_FC;
                        wdata_d = REQ0_WDATA;
                    end
                end
            end
            S_ISSUE: begin
                if (ENG_BUSY) begin
                    state_d = S_WAIT;
                end else begin
                    start_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (ENG_DONE) begin
                    state_d = S_DONE;
                    grant_d = 2'b00;
                    done0_d = grant_q[0];
                    done1_d = grant_q[1];
                    if (read_q) begin
                        rdata_d = ENG_RDATA;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State and output registers; reset abandons any cycle in flight
    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= S_IDLE;
            starve_q <= 4'd0;
            grant_q  <= 2'b00;
            start_q  <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata_q  <= 32'd0;
            addr_q   <= '0;
            size_q   <= 2'd0;
            read_q   <= 1'b0;
            fc_q     <= 3'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            grant_q  <= grant_d;
            start_q  <= start_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            read_q   <= read_d;
            fc_q     <= fc_d;
            wdata_q  <= wdata_d;
        end
    end

    assign REQ0_DONE = done0_q;
    assign REQ1_DONE = done1_q;
    assign RDATA     = rdata_q;
    assign GRANT     = grant_q;
    assign ENG_START = start_q;
    assign ENG_ADDR  = addr_q;
    assign ENG_SIZE  = size_q;
    assign ENG_READ  = read_q;
    assign ENG_FC    = fc_q;
    assign ENG_WDATA = wdata_q;

endmodule

// File: tb/tb_bus_access_arbiter.sv
// tb/tb_bus_access_arbiter.sv - scoreboard bench for bus_access_arbiter
module tb_bus_access_arbiter;

    logic        SYSCLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        REQ0_VALID = 1'b0;
    logic [23:0] REQ0_ADDR = '0;
    logic [1:0]  REQ0_SIZE = '0;
    logic        REQ0_READ = 1'b0;
    logic [2:0]  REQ0_FC = '0;
    logic [31:0] REQ0_WDATA = '0;
    logic        REQ0_DONE;
    logic        REQ1_VALID = 1'b0;
    logic [23:0] REQ1_ADDR = '0;
    logic [1:0]  REQ1_SIZE = '0;
    logic        REQ1_READ = 1'b0;
    logic [2:0]  REQ1_FC = '0;
    logic [31:0] REQ1_WDATA = '0;
    logic        REQ1_DONE;
    logic [31:0] RDATA;
    logic [1:0]  GRANT;
    logic        EXT_MASTER = 1'b0;
    logic        ENG_START;
    logic [23:0] ENG_ADDR;
    logic [1:0]  ENG_SIZE;
    logic        ENG_READ;
    logic [2:0]  ENG_FC;
    logic [31:0] ENG_WDATA;
    logic        ENG_BUSY = 1'b0;
    logic        ENG_DONE = 1'b0;
    logic [31:0] ENG_RDATA = '0;

    bus_access_arbiter #(.STARVE_LIMIT(4), .ADDR_W(24)) dut (
        .SYSCLK(SYSCLK), .nRESET(nRESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_SIZE(REQ0_SIZE),
        .REQ0_READ(REQ0_READ), .REQ0_FC(REQ0_FC), .REQ0_WDATA(REQ0_WDATA), .REQ0_DONE(REQ0_DONE),
        .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_SIZE(REQ1_SIZE),
        .REQ1_READ(REQ1_READ), .REQ1_FC(REQ1_FC), .REQ1_WDATA(REQ1_WDATA), .REQ1_DONE(REQ1_DONE),
        .RDATA(RDATA), .GRANT(GRANT), .EXT_MASTER(EXT_MASTER),
        .ENG_START(ENG_START), .ENG_ADDR(ENG_ADDR), .ENG_SIZE(ENG_SIZE), .ENG_READ(ENG_READ),
        .ENG_FC(ENG_FC), .ENG_WDATA(ENG_WDATA), .ENG_BUSY(ENG_BUSY), .ENG_DONE(ENG_DONE),
        .ENG_RDATA(ENG_RDATA)
    );

    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        logic        port;
        logic [23:0] addr;
        logic [1:0]  size;
        logic        read;
        logic [2:0]  fc;
        logic [31:0] wdata;
        logic [31:0] edata;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_rdata = 32'd0;

    task automatic tick();
        @(posedge SYSCLK);
        @(negedge SYSCLK);
    endtask

    task automatic drive_req(input exp_t e);
        if (e.port) begin
            REQ1_ADDR = e.addr; REQ1_SIZE = e.size; REQ1_READ = e.read;
            REQ1_FC = e.fc; REQ1_WDATA = e.wdata; REQ1_VALID = 1'b1;
        end else begin
            REQ0_ADDR = e.addr; REQ0_SIZE = e.size; REQ0_READ = e.read;
            REQ0_FC = e.fc; REQ0_WDATA = e.wdata; REQ0_VALID = 1'b1;
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [23:0] a, input logic [1:0] s,
                                input logic r, input logic [2:0] f, input logic [31:0] w,
                                input logic [31:0] d);
        exp_t e;
        e.port = p; e.addr = a; e.size = s; e.read = r; e.fc = f; e.wdata = w; e.edata = d;
        return e;
    endfunction

    // Pops the next expected cycle, plays the engine for it and checks grant, fields and completion
    task automatic serve(input logic ext_in_wait, input logic drop_in_wait);
        exp_t        e;
        int          n;
        logic [1:0]  g;
        logic [92:0] want_f;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got 0 entries, required at least 1");
            return;
        end
        e = sb.pop_front();
        g = e.port ? 2'b10 : 2'b01;
        want_f = {g, e.addr, e.size, e.read, e.fc, e.wdata};
        n = 0;
        while (ENG_START !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (ENG_START !== 1'b1) begin
            n_fail++;
            $display("FAIL start_timeout: got ENG_START=%b, required 1", ENG_START);
            return;
        end
        n_checks++;
        if ({GRANT, ENG_ADDR, ENG_SIZE, ENG_READ, ENG_FC, ENG_WDATA} !== want_f) begin
            n_fail++;
            $display("FAIL grant_fields: got %h, required %h",
                     {GRANT, ENG_ADDR, ENG_SIZE, ENG_READ, ENG_FC, ENG_WDATA}, want_f);
        end
        tick();
        n_checks++;
        if (ENG_START !== 1'b1) begin
            n_fail++;
            $display("FAIL start_hold: got %b, required 1", ENG_START);
        end
        ENG_BUSY = 1'b1;
        tick();
        n_checks++;
        if (ENG_START !== 1'b0) begin
            n_fail++;
            $display("FAIL start_drop: got %b, required 0", ENG_START);
        end
        if (ext_in_wait) EXT_MASTER = 1'b1;
        if (drop_in_wait) begin
            if (e.port) begin
                REQ1_VALID = 1'b0; REQ1_ADDR = ~REQ1_ADDR; REQ1_WDATA = ~REQ1_WDATA;
            end else begin
                REQ0_VALID = 1'b0; REQ0_ADDR = ~REQ0_ADDR; REQ0_WDATA = ~REQ0_WDATA;
            end
        end
        tick();
        tick();
        n_checks++;
        if ({GRANT, ENG_ADDR, ENG_SIZE, ENG_READ, ENG_FC, ENG_WDATA} !== want_f) begin
            n_fail++;
            $display("FAIL latch_hold: got %h, required %h",
                     {GRANT, ENG_ADDR, ENG_SIZE, ENG_READ, ENG_FC, ENG_WDATA}, want_f);
        end
        ENG_RDATA = e.edata;
        ENG_DONE = 1'b1;
        tick();
        ENG_DONE = 1'b0;
        ENG_BUSY = 1'b0;
        ENG_RDATA = 32'hDEAD_0000;
        if (e.read) model_rdata = e.edata;
        n_checks++;
        if ({REQ1_DONE, REQ0_DONE, GRANT} !== {e.port, ~e.port, 2'b00}) begin
            n_fail++;
            $display("FAIL done_pulse: got d1=%b d0=%b grant=%b, required d1=%b d0=%b grant=00",
                     REQ1_DONE, REQ0_DONE, GRANT, e.port, ~e.port);
        end
        n_checks++;
        if (RDATA !== model_rdata) begin
            n_fail++;
            $display("FAIL rdata: got %h, required %h", RDATA, model_rdata);
        end
    endtask

    task automatic test_reset();
        @(negedge SYSCLK);
        n_checks++;
        if ({GRANT, ENG_START, REQ0_DONE, REQ1_DONE, RDATA, ENG_ADDR, ENG_SIZE, ENG_READ,
             ENG_FC, ENG_WDATA} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        tick();
        nRESET = 1'b1;
        tick();
    endtask

    task automatic test_port0_read();
        exp_t e;
        e = mk(1'b0, 24'hDFF006, 2'd2, 1'b1, 3'd5, 32'h0, 32'h0000BEEF);
        drive_req(e);
        sb.push_back(e);
        tick();
        n_checks++;
        if (ENG_START !== 1'b1 || ENG_ADDR !== 24'hDFF006) begin
            n_fail++;
            $display("FAIL p0_latency: got start=%b addr=%h, required start=1 addr=dff006",
                     ENG_START, ENG_ADDR);
        end
        serve(1'b0, 1'b0);
        REQ0_VALID = 1'b0;
        tick();
        n_checks++;
        if ({REQ0_DONE, ENG_START, GRANT} !== 4'b0000) begin
            n_fail++;
            $display("FAIL p0_single_pulse: got %b, required 0000", {REQ0_DONE, ENG_START, GRANT});
        end
        n_checks++;
        if (RDATA !== 32'h0000BEEF) begin
            n_fail++;
            $display("FAIL p0_rdata: got %h, required 0000beef", RDATA);
        end
    endtask

    task automatic test_starvation();
        logic p;
        drive_req(mk(1'b0, 24'h000100, 2'd2, 1'b1, 3'd1, 32'h0, 32'h0));
        drive_req(mk(1'b1, 24'h000200, 2'd1, 1'b1, 3'd2, 32'h0, 32'h0));
        for (int i = 0; i < 10; i++) begin
            p = (i == 4 || i == 9);
            if (p) sb.push_back(mk(1'b1, 24'h000200, 2'd1, 1'b1, 3'd2, 32'h0, 32'hA000_0000 + i));
            else   sb.push_back(mk(1'b0, 24'h000100, 2'd2, 1'b1, 3'd1, 32'h0, 32'hB000_0000 + i));
        end
        for (int i = 0; i < 10; i++) serve(1'b0, 1'b0);
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_ext_master_gate();
        exp_t e;
        int   bad;
        EXT_MASTER = 1'b1;
        e = mk(1'b1, 24'h00F000, 2'd2, 1'b1, 3'd6, 32'h0, 32'h0000CAFE);
        drive_req(e);
        sb.push_back(e);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ENG_START !== 1'b0 || GRANT !== 2'b00) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ext_gate: got %0d cycles with a grant, required 0", bad);
        end
        EXT_MASTER = 1'b0;
        tick();
        n_checks++;
        if (ENG_START !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_release: got ENG_START=%b, required 1", ENG_START);
        end
        serve(1'b0, 1'b0);
        REQ1_VALID = 1'b0;
        tick();
    endtask

    task automatic test_ext_in_wait();
        exp_t e;
        int   bad;
        e = mk(1'b0, 24'h00A000, 2'd1, 1'b1, 3'd5, 32'h0, 32'h000000A5);
        drive_req(e);
        sb.push_back(e);
        serve(1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ENG_START !== 1'b0 || GRANT !== 2'b00 || REQ0_DONE !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ext_wait_nogrant: got %0d bad cycles, required 0", bad);
        end
        REQ0_VALID = 1'b0;
        tick();
        EXT_MASTER = 1'b0;
        tick();
    endtask

    task automatic test_p1_long_write_drop();
        exp_t e;
        e = mk(1'b1, 24'h040000, 2'd3, 1'b0, 3'd1, 32'h12345678, 32'hFFFF_FFFF);
        drive_req(e);
        sb.push_back(e);
        serve(1'b0, 1'b1);
        tick();
        n_checks++;
        if ({REQ1_DONE, GRANT, ENG_START} !== 4'b0000 || RDATA !== model_rdata) begin
            n_fail++;
            $display("FAIL p1_write_after: got d1=%b grant=%b start=%b rdata=%h, required 0 00 0 %h",
                     REQ1_DONE, GRANT, ENG_START, RDATA, model_rdata);
        end
    endtask

    task automatic test_reset_mid_cycle();
        exp_t e;
        int   bad;
        drive_req(mk(1'b0, 24'h001234, 2'd2, 1'b1, 3'd5, 32'h0, 32'h0));
        tick();
        ENG_BUSY = 1'b1;
        tick();
        tick();
        nRESET = 1'b0;
        #1;
        n_checks++;
        if ({GRANT, ENG_START, REQ0_DONE, REQ1_DONE, RDATA, ENG_ADDR, ENG_SIZE, ENG_READ,
             ENG_FC, ENG_WDATA} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got grant=%b start=%b rdata=%h addr=%h, required all 0",
                     GRANT, ENG_START, RDATA, ENG_ADDR);
        end
        model_rdata = 32'd0;
        ENG_RDATA = 32'h5555_5555;
        ENG_DONE = 1'b1;
        bad = 0;
        tick();
        ENG_DONE = 1'b0;
        ENG_BUSY = 1'b0;
        if (REQ0_DONE !== 1'b0 || REQ1_DONE !== 1'b0) bad++;
        tick();
        if (REQ0_DONE !== 1'b0 || REQ1_DONE !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d cycles with DONE, required 0", bad);
        end
        e = mk(1'b0, 24'h005678, 2'd2, 1'b1, 3'd6, 32'h0, 32'h00C0FFEE);
        drive_req(e);
        sb.push_back(e);
        nRESET = 1'b1;
        serve(1'b0, 1'b0);
        REQ0_VALID = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    always @(negedge SYSCLK) begin
        if (GRANT === 2'b11) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_onehot: got 11, required one-hot or 00");
        end
    end

    initial begin
        test_reset();
        test_port0_read();
        test_starvation();
        test_ext_master_gate();
        test_ext_in_wait();
        test_p1_long_write_drop();
        test_reset_mid_cycle();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
